// File: rtl/id_ex_stage.sv
// id_ex_stage: ID-to-EX pipeline register of the RISC-V pipeline.
// It captures the operands, immediate, PC and decode control of the ID
// instruction and presents them to EX one cycle later. It also inserts
// bubbles for load-use hazards, branch flush and an empty ID slot, and it
// freezes while EX holds.
// Optional build macro ID_WB_BYPASS_EN: when it is defined, a same-cycle
// writeback to a source register is forwarded into ex_rdata1/ex_rdata2.
module id_ex_stage #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_alusrc,
  input  logic              id_branch,
  input  logic [1:0]        id_aluop,
  input  logic [3:0]        id_funct,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic [1:0]        ex_aluop,
  output logic [3:0]        ex_funct
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              alusrc;
    logic              branch;
    logic [1:0]        aluop;
    logic [3:0]        funct;
  } ex_reg_t;

  ex_reg_t           ex_q;
  ex_reg_t           ex_d;
  logic              load_use;
  logic [DATA_W-1:0] op1_sel;
  logic [DATA_W-1:0] op2_sel;

  // Hazard detection: an in-flight load whose destination is read by ID.
  always_comb begin
    load_use = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
               ((id_uses_rs1 & (ex_q.rd == id_rs1)) |
                (id_uses_rs2 & (ex_q.rd == id_rs2)));
    id_stall = ~reset & (ex_hold | (load_use & ~flush));
  end

`ifdef ID_WB_BYPASS_EN
  // Operand select: take the writeback value when it targets a source register.
  always_comb begin
    op1_sel = id_rdata1;
    op2_sel = id_rdata2;
    if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs1)) op1_sel = wb_data;
    if (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs2)) op2_sel = wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = wb_regwrite ^ (^wb_rd) ^ (^wb_data);

  // Operand select: the register file read data is used unchanged.
  always_comb begin
    op1_sel = id_rdata1;
    op2_sel = id_rdata2;
  end
`endif

  // Next EX contents: hold, then bubble (flush / load-use / empty ID), then load.
  always_comb begin
    ex_d = ex_q;
    if (ex_hold) begin
      ex_d = ex_q;
    end else if (flush || load_use || !id_valid) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = 1'b1;
      ex_d.pc       = id_pc;
      ex_d.rdata1   = op1_sel;
      ex_d.rdata2   = op2_sel;
      ex_d.imm      = id_imm;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.memwrite = id_memwrite;
      ex_d.memtoreg = id_memtoreg;
      ex_d.alusrc   = id_alusrc;
      ex_d.branch   = id_branch;
      ex_d.aluop    = id_aluop;
      ex_d.funct    = id_funct;
    end
  end

  // EX register; reset clears data as well as control.
  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rdata1   = ex_q.rdata1;
  assign ex_rdata2   = ex_q.rdata2;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_branch   = ex_q.branch;
  assign ex_aluop    = ex_q.aluop;
  assign ex_funct    = ex_q.funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, normal flow, load-use, flush, hold,
// writeback bypass and reset in the middle of operation.
module tb_id_ex_stage;
  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm;
  logic              id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch;
  logic [1:0]        id_aluop;
  logic [3:0]        id_funct;
  logic              flush, ex_hold;
  logic              wb_regwrite;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              id_stall, ex_valid;
  logic [DATA_W-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
  logic [REG_W-1:0]  ex_rs1, ex_rs2, ex_rd;
  logic              ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch;
  logic [1:0]        ex_aluop;
  logic [3:0]        ex_funct;

  int n_chk  = 0;
  int n_pass = 0;
  logic [DATA_W-1:0] exp_byp;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_branch(id_branch),
    .id_aluop(id_aluop), .id_funct(id_funct), .flush(flush), .ex_hold(ex_hold),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .ex_funct(ex_funct)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    id_alusrc = 0; id_branch = 0; id_aluop = '0; id_funct = '0;
  endtask

  // Load instruction: ld x<rd>, 0(x2)
  task automatic set_ld(input logic [63:0] pc, input logic [4:0] rd);
    clr_id();
    id_valid = 1; id_pc = pc; id_rs1 = 5'd2; id_uses_rs1 = 1; id_rd = rd;
    id_memread = 1; id_memtoreg = 1; id_regwrite = 1; id_alusrc = 1;
  endtask

  // Register-register add: add x<rd>, x<rs1>, x<rs2>
  task automatic set_add(input logic [63:0] pc, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd);
    clr_id();
    id_valid = 1; id_pc = pc; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2;
    id_uses_rs2 = u2; id_rd = rd; id_regwrite = 1; id_aluop = 2'd2;
    id_rdata1 = 64'hAA; id_rdata2 = 64'hBB;
  endtask

  initial begin
    clr_id();
    flush = 0; ex_hold = 0; wb_regwrite = 0; wb_rd = '0; wb_data = '0;

    // Reset held for two cycles with a valid instruction in ID.
    reset = 1; id_valid = 1; id_pc = 64'h100; id_regwrite = 1;
    #1;
    check("rst_stall0", id_stall, 0);
    step();
    check("rst_valid0", ex_valid, 0);
    check("rst_pc0", ex_pc, 0);
    ex_hold = 1;
    #1;
    check("rst_stall_hold", id_stall, 0);
    step();
    check("rst_valid1", ex_valid, 0);
    check("rst_pc1", ex_pc, 0);
    check("rst_regwrite", ex_regwrite, 0);
    ex_hold = 0; reset = 0;
    step();
    check("rel_valid", ex_valid, 1);
    check("rel_pc", ex_pc, 64'h100);

    // Normal flow.
    clr_id();
    id_valid = 1; id_pc = 64'h104; id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd5;
    id_uses_rs1 = 1; id_rdata1 = 64'h1234; id_rdata2 = 64'h5678;
    id_imm = 64'hFFFF_FFFF_FFFF_FFF0; id_regwrite = 1; id_alusrc = 1;
    id_aluop = 2'd2; id_funct = 4'hD; id_branch = 1; id_memwrite = 1;
    step();
    check("nf_valid", ex_valid, 1);
    check("nf_rdata1", ex_rdata1, 64'h1234);
    check("nf_rdata2", ex_rdata2, 64'h5678);
    check("nf_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF0);
    check("nf_rd", ex_rd, 5);
    check("nf_rs1", ex_rs1, 3);
    check("nf_rs2", ex_rs2, 4);
    check("nf_regwrite", ex_regwrite, 1);
    check("nf_alusrc", ex_alusrc, 1);
    check("nf_aluop", ex_aluop, 2);
    check("nf_funct", ex_funct, 4'hD);
    check("nf_branch", ex_branch, 1);
    check("nf_memwrite", ex_memwrite, 1);

    // Empty ID slot gives a bubble.
    clr_id();
    id_pc = 64'h55; id_rd = 5'd6; id_regwrite = 1;
    step();
    check("idle_valid", ex_valid, 0);
    check("idle_rd", ex_rd, 0);
    check("idle_pc", ex_pc, 0);

    // Load-use on rs1.
    set_ld(64'h200, 5'd7);
    step();
    check("ld_memread", ex_memread, 1);
    set_add(64'h204, 5'd7, 1, 5'd1, 1, 5'd8);
    #1;
    check("lu_stall", id_stall, 1);
    step();
    check("lu_bub_valid", ex_valid, 0);
    check("lu_bub_regwrite", ex_regwrite, 0);
    check("lu_bub_rd", ex_rd, 0);
    check("lu_bub_rdata1", ex_rdata1, 0);
    check("lu_stall_off", id_stall, 0);
    step();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_rd", ex_rd, 8);
    check("lu_add_rdata1", ex_rdata1, 64'hAA);

    // Load-use on rs2.
    set_ld(64'h210, 5'd7);
    step();
    set_add(64'h214, 5'd1, 1, 5'd7, 1, 5'd8);
    #1;
    check("lu_rs2_stall", id_stall, 1);
    // Same address on rs2 but rs2 not read: no hazard.
    id_uses_rs2 = 0;
    #1;
    check("lu_rs2_unused", id_stall, 0);
    step();
    check("lu_rs2_unused_ld", ex_valid, 1);

    // Load into x0 never stalls.
    set_ld(64'h220, 5'd0);
    step();
    set_add(64'h224, 5'd0, 1, 5'd0, 1, 5'd8);
    #1;
    check("x0_stall", id_stall, 0);
    step();
    check("x0_valid", ex_valid, 1);
    check("x0_pc", ex_pc, 64'h224);

    // Flush takes precedence over load-use.
    set_ld(64'h300, 5'd7);
    step();
    set_add(64'h304, 5'd7, 1, 5'd1, 1, 5'd8);
    flush = 1;
    #1;
    check("fl_stall", id_stall, 0);
    step();
    check("fl_valid", ex_valid, 0);
    check("fl_rd", ex_rd, 0);
    check("fl_pc", ex_pc, 0);
    flush = 0;
    set_add(64'h310, 5'd1, 1, 5'd2, 1, 5'd10);
    step();
    check("fl_next_pc", ex_pc, 64'h310);
    check("fl_next_rd", ex_rd, 10);

    // Hold freezes EX for three cycles and ignores flush pulses.
    clr_id();
    id_valid = 1; id_pc = 64'h400; id_rd = 5'd11; id_aluop = 2'd2; id_funct = 4'h5;
    id_regwrite = 1;
    step();
    set_add(64'h500, 5'd3, 1, 5'd4, 1, 5'd12);
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      #1;
      check("hold_stall", id_stall, 1);
      step();
      check("hold_pc", ex_pc, 64'h400);
      check("hold_valid", ex_valid, 1);
      check("hold_rd", ex_rd, 11);
      check("hold_funct", ex_funct, 4'h5);
    end
    ex_hold = 0; flush = 0;
    #1;
    check("hold_rel_stall", id_stall, 0);
    step();
    check("hold_rel_pc", ex_pc, 64'h500);
    check("hold_rel_rd", ex_rd, 12);

    // Writeback bypass on both operands.
    clr_id();
    id_valid = 1; id_pc = 64'h600; id_rs1 = 5'd9; id_rs2 = 5'd9; id_uses_rs1 = 1;
    id_uses_rs2 = 1; id_rdata1 = 64'h2; id_rdata2 = 64'h1; id_rd = 5'd13;
    wb_regwrite = 1; wb_rd = 5'd9; wb_data = 64'hDEAD;
    step();
`ifdef ID_WB_BYPASS_EN
    exp_byp = 64'hDEAD;
    check("byp_rdata1", ex_rdata1, 64'hDEAD);
`else
    exp_byp = 64'h1;
    check("byp_rdata1", ex_rdata1, 64'h2);
`endif
    check("byp_rdata2", ex_rdata2, exp_byp);
    // Writeback to x0 is never forwarded.
    id_rs1 = 5'd0; id_rs2 = 5'd0; wb_rd = 5'd0;
    step();
    check("byp_x0_rdata1", ex_rdata1, 64'h2);
    check("byp_x0_rdata2", ex_rdata2, 64'h1);
    // Matching address without writeback enable is not forwarded.
    id_rs2 = 5'd9; wb_rd = 5'd9; wb_regwrite = 0;
    step();
    check("byp_nowe_rdata2", ex_rdata2, 64'h1);
    wb_regwrite = 0; wb_rd = '0; wb_data = '0;

    // Reset in the middle of operation discards the EX instruction.
    clr_id();
    id_valid = 1; id_pc = 64'h700; id_rd = 5'd14; id_memread = 1;
    step();
    check("mid_pre_valid", ex_valid, 1);
    reset = 1;
    #1;
    check("mid_stall", id_stall, 0);
    step();
    check("mid_valid", ex_valid, 0);
    check("mid_pc", ex_pc, 0);
    check("mid_memread", ex_memread, 0);
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the RISC-V pipeline. Sits directly downstream of the register file read ports.
- Captures the two register read values, immediate, PC and decode control for the instruction in ID, and presents them to EX one cycle later.
- Detects load-use hazards and inserts bubbles. Honours branch flush and downstream hold.
- Optionally bypasses the same-cycle writeback value around the register file.

Parameters:
- DATA_W, 64, datapath width (register data, PC, immediate).
- REG_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  DATA_W  PC of the ID instruction.
- id_rs1, id_rs2, id_rd  in  REG_W  source and destination register addresses.
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2.
- id_rdata1, id_rdata2  in  DATA_W  register file Readdata1/Readdata2.
- id_imm  in  DATA_W  sign-extended immediate.
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch  in  1  decode control.
- id_aluop  in  2  ALU operation class.
- id_funct  in  4  {funct7[5], funct3}.
- flush  in  1  branch taken in EX; kill the ID instruction.
- ex_hold  in  1  EX cannot accept; freeze this stage.
- wb_regwrite  in  1  writeback enable (same signal as register file RegWrite).
- wb_rd  in  REG_W  writeback address.
- wb_data  in  DATA_W  writeback data.
- id_stall  out  1  combinational; IF/ID must hold.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  DATA_W  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  REG_W  registered copies.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch  out  1  registered control.
- ex_aluop  out  2  registered control.
- ex_funct  out  4  registered control.

Behaviour:
- Single clock (clk); reset is synchronous and active-high. reset=1 at a rising edge clears every ex_* output to 0 (ex_valid=0, all data/control 0).
- id_stall is 0 whenever reset=1. Reset mid-operation discards the held or in-flight instruction.
- Latency: an accepted ID instruction appears on ex_* exactly 1 cycle later. No internal FSM beyond the EX register plus ex_valid.
- load_use = id_valid & ex_valid & ex_memread & (ex_rd != 0) & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
- Next-state priority per rising edge:
  1. reset → clear all outputs.
  2. ex_hold → all ex_* keep their value; flush is ignored. The flush source keeps flush asserted until hold drops.
  3. flush → bubble.
  4. load_use → bubble.
  5. id_valid=0 → bubble.
  6. Otherwise → load all ID fields, ex_valid=1.
- Bubble: every ex_* output, including data and ex_rd, is 0.
- id_stall = ~reset & (ex_hold | (load_use & ~flush)). Flush suppresses the load-use stall, since the dependent instruction is dead.
- A load-use stall lasts exactly 1 cycle: after the bubble, ex_memread=0, so load_use deasserts.
- Register address 0 never triggers a hazard or a bypass.
- Widths: no arithmetic in this block. All fields are passed bit-exact.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: when loading (priority case 6), if wb_regwrite & (wb_rd != 0) & (wb_rd == id_rs1), then ex_rdata1 captures wb_data instead of id_rdata1. Same rule for rs2/ex_rdata2, evaluated independently, so both may bypass at once. This covers the register file updating at the same edge it is read.
- Not defined: ex_rdata1/2 always capture id_rdata1/2. The wb_* ports remain present but unused.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with id_valid=1, id_pc=0x100 → all ex_* = 0 and id_stall=0 each cycle. Release reset → next edge ex_valid=1, ex_pc=0x100.
2. Normal flow: id_rs1=3, id_rd=5, id_rdata1=0x1234, id_imm=0xFFFF_FFFF_FFFF_FFF0, id_regwrite=1 → one cycle later ex_valid=1, ex_rdata1=0x1234, ex_imm unchanged, ex_rd=5, ex_regwrite=1.
3. Load-use: EX holds ld x7 (ex_memread=1, ex_rd=7); ID add with id_uses_rs1=1, id_rs1=7 → id_stall=1. Next cycle ex_valid=0 with all control 0. Following edge the add enters with id_stall=0. Repeat with ex_rd=0 → no stall.
4. Flush vs load-use: same setup as 3 plus flush=1 → id_stall=0, next cycle bubble. The add is never loaded.
5. Hold: ex_hold=1 for 3 cycles while id_valid=1 and flush pulses → ex_* constant throughout, id_stall=1. After release, ID content loads on the first free edge.
6. Bypass: wb_regwrite=1, wb_rd=9, wb_data=0xDEAD, id_rs2=9, id_rdata2=0x1 → ex_rdata2=0xDEAD with ID_WB_BYPASS_EN, 0x1 without. With wb_rd=0 → 0x1 in both builds.
